// File: rtl/hsv_hue_sat.sv
// hsv_hue_sat: saturation and hue from R/G/B/max/min via one shared 16-step restoring divider.
// Define HSV_GRAY_SHORTCUT_EN to send grey pixels (max == min) straight to DONE.
module hsv_hue_sat (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [9:0] R,
  input  logic signed [9:0] G,
  input  logic signed [9:0] B,
  input  logic signed [9:0] V,
  input  logic signed [9:0] min,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [8:0]        H,
  output logic [7:0]        S,
  output logic [7:0]        V_out,
  output logic              out_valid,
  input  logic              out_ready
);
  typedef enum logic [1:0] {IDLE, DIV_S, DIV_H, DONE} state_t;
  state_t state;
  logic [7:0] r_q, g_q, b_q, v_q, delta, s_q, rem, rem_n, dvs, delta_in, mag;
  logic [15:0] dq, dq_n;
  logic [3:0] cnt;
  logic [8:0] rem_sh, num, off;
  logic [6:0] hq;
  logic [10:0] h_sum, h_adj;
  logic [8:0] h_fin;
  logic ge;
  logic unused;
  assign unused = ^{R[9:8], G[9:8], B[9:8], V[9:8], min[9:8]};
  assign in_ready = state == IDLE;
  assign delta_in = V[7:0] - min[7:0];
  // one restoring step: shift in the next dividend bit, subtract when it fits
  assign dvs = state == DIV_S ? v_q : delta;
  assign rem_sh = {rem, dq[15]};
  assign ge = rem_sh >= {1'b0, dvs};
  assign rem_n = ge ? 8'(rem_sh - {1'b0, dvs}) : rem_sh[7:0];
  assign dq_n = {dq[14:0], ge};
  // hue sector by max-component priority; num is a 9-bit two's-complement difference
  assign num = v_q == r_q ? {1'b0, g_q} - {1'b0, b_q} :
               v_q == g_q ? {1'b0, b_q} - {1'b0, r_q} : {1'b0, r_q} - {1'b0, g_q};
  assign off = v_q == r_q ? 9'd0 : v_q == g_q ? 9'd120 : 9'd240;
  assign mag = num[8] ? 8'(~num[7:0] + 8'd1) : num[7:0];
  assign hq = delta == 8'd0 ? 7'd0 : dq_n[6:0];
  assign h_sum = num[8] ? {2'b0, off} - {4'b0, hq} : {2'b0, off} + {4'b0, hq};
  assign h_adj = h_sum[10] ? h_sum + 11'd360 : h_sum;
  assign h_fin = h_adj == 11'd360 ? 9'd0 : h_adj[8:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {r_q, g_q, b_q, v_q, delta, s_q, rem} <= '0;
      dq <= '0;
      cnt <= '0;
      H <= '0;
      S <= '0;
      V_out <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r_q <= R[7:0];
          g_q <= G[7:0];
          b_q <= B[7:0];
          v_q <= V[7:0];
          delta <= delta_in;
          dq <= 16'd255 * {8'd0, delta_in};
          rem <= '0;
          cnt <= '0;
          state <= DIV_S;
`ifdef HSV_GRAY_SHORTCUT_EN
          if (delta_in == 8'd0) begin
            H <= '0;
            S <= '0;
            V_out <= V[7:0];
            out_valid <= 1'b1;
            state <= DONE;
          end
`endif
        end
        DIV_S: begin
          rem <= rem_n;
          dq <= dq_n;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            s_q <= v_q == 8'd0 ? 8'd0 : dq_n[7:0];
            dq <= 16'd60 * {8'd0, mag};
            rem <= '0;
            state <= DIV_H;
          end
        end
        DIV_H: begin
          rem <= rem_n;
          dq <= dq_n;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            H <= h_fin;
            S <= s_q;
            V_out <= v_q;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hsv_hue_sat.sv
// tb_hsv_hue_sat: directed pixels with hand-computed H/S/V; a scoreboard monitor checks every output.
module tb_hsv_hue_sat;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic signed [9:0] R = 0, G = 0, B = 0, V = 0, min = 0;
  logic [8:0] H;
  logic [7:0] S, V_out;
  int cyc = 0, errors = 0, checks = 0;
  bit seen = 0;
  typedef struct {logic [8:0] h; logic [7:0] s; logic [7:0] v; int acc; int lat;} exp_t;
  exp_t q[$];
`ifdef HSV_GRAY_SHORTCUT_EN
  localparam int GL = 0;
`else
  localparam int GL = 32;
`endif

  hsv_hue_sat dut (.clk(clk), .rst_n(rst_n), .R(R), .G(G), .B(B), .V(V), .min(min),
    .in_valid(in_valid), .in_ready(in_ready), .H(H), .S(S), .V_out(V_out),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic [9:0] r, g, b, v, mn);
    R = r; G = g; B = b; V = v; min = mn;
  endtask

  task automatic send(input logic [9:0] r, g, b, v, mn, input logic [8:0] eh,
                      input logic [7:0] es, input int lat);
    int n = 0;
    exp_t e;
    set_px(r, g, b, v, mn);
    in_valid = 1;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) timeout("send");
    tick();
    e.h = eh; e.s = es; e.v = v[7:0]; e.acc = cyc; e.lat = lat;
    q.push_back(e);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin tick(); n++; end
    if (q.size() > 0) timeout("drain");
    tick();
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (!seen) begin
        seen = 1;
        if (q.size() > 0) chk("latency", cyc - q[0].acc, q[0].lat);
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: H=%0d S=%0d V_out=%0d with nothing expected", H, S, V_out);
        end else begin
          e = q.pop_front();
          chk("H", H, e.h);
          chk("S", S, e.s);
          chk("V_out", V_out, e.v);
        end
        seen = 0;
      end
    end
  end

  initial begin
    int n;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    tick();
    rst_n = 1;
    tick();
    chk("rst_HSV", {H, S, V_out}, 0);
    send(10'h3FF, 0, 0, 10'h2FF, 0, 0, 255, 32);
    drain();
    send(100, 50, 200, 200, 50, 260, 191, 32);
    drain();
    send(255, 0, 128, 255, 0, 330, 255, 32);
    drain();
    send(0, 255, 0, 255, 0, 120, 255, 32);
    drain();
    send(100, 100, 100, 100, 100, 0, 0, GL);
    drain();
    send(0, 0, 0, 0, 0, 0, 0, GL);
    drain();
    // stall in DONE with a competing request that must be ignored
    out_ready = 0;
    send(100, 50, 200, 200, 50, 260, 191, 32);
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    if (!out_valid) timeout("stall_wait");
    set_px(255, 0, 0, 255, 0);
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", {out_valid, in_ready, H, S, V_out}, {1'b1, 1'b0, 9'd260, 8'd191, 8'd200});
    end
    out_ready = 1;
    tick();
    chk("release", {out_valid, in_ready}, 2'b01);
    tick();
    begin
      exp_t e;
      e.h = 0; e.s = 255; e.v = 255; e.acc = cyc; e.lat = 32;
      q.push_back(e);
    end
    in_valid = 0;
    chk("second_accepted", in_ready, 0);
    drain();
    // reset in the middle of the saturation division
    send(255, 0, 128, 255, 0, 330, 255, 32);
    repeat (10) tick();
    rst_n = 0;
    q.delete();
    #1;
    chk("midrst", {out_valid, in_ready, H, S, V_out}, {1'b0, 1'b1, 25'd0});
    tick();
    rst_n = 1;
    repeat (40) tick();
    chk("midrst_no_output", out_valid, 0);
    send(0, 255, 0, 255, 0, 120, 255, 32);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hsv_hue_sat.md
# hsv_hue_sat

Second stage of the RGB-to-HSV path. It consumes the pixel's R, G, B together with the max (V) and min values produced by the max/min stage, and computes saturation S and hue H. A single shared 16-step restoring divider performs both divisions. Valid/ready handshakes sit on both sides so the stage can be stalled by the downstream HSV consumer.

## Interface
- No parameters; all widths fixed.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- R, G, B  input  10 (signed)  pixel components; only bits [7:0] used, bits [9:8] ignored
- V, min  input  10 (signed)  max and min of R, G, B from the max/min stage; only bits [7:0] used
- in_valid  input  1  input bundle valid
- in_ready  output  1  stage can accept; equals (state == IDLE)
- H  output  9  hue, 0..359 degrees
- S  output  8  saturation, 0..255
- V_out  output  8  registered copy of V[7:0]
- out_valid  output  1  H/S/V_out valid
- out_ready  input  1  downstream accepts

## Operation
- States: IDLE, DIV_S, DIV_H, DONE.
- **IDLE**
  - On in_valid && in_ready, register R/G/B/V/min (8 bits each) and compute delta = V - min (8 bit, unsigned).
  - Go to DIV_S.
- **DIV_S**
  - Dividend = 255*delta (16 bit); divisor = V.
  - 16 restoring iterations, one per cycle. S = quotient[7:0], truncated.
  - If V == 0, the quotient is forced to 0.
- **DIV_H**
  - Select the max component by priority:
    - V == R: num = G - B, offset 0.
    - else V == G: num = B - R, offset 120.
    - else: num = R - G, offset 240.
  - Dividend = 60*|num| (14 bit, zero-extended to 16); divisor = delta. 16 iterations give q (0..60). If delta == 0, q = 0.
  - num >= 0: H = offset + q.
  - num < 0: H = offset - q, then add 360 if the result is negative.
  - If H == 360, force H to 0.
- **DONE**
  - out_valid = 1; H, S and V_out are held stable.
  - On out_ready, go to IDLE.
- No overlap: a new input is accepted only from IDLE, so throughput is at most one pixel per 34 cycles.
- Reset values:
  - state IDLE
  - H = 0, S = 0, V_out = 0
  - out_valid = 0
  - in_ready = 1 while rst_n is low and after release
  - divider registers 0

## Timing
- The accept edge is edge k. DIV_S occupies edges k+1..k+16 and DIV_H occupies edges k+17..k+32.
- out_valid rises after edge k+32, a latency of 32 cycles with no stall.
- H and S change only on the edge that enters DONE; they hold through any out_ready stall.
- DONE with out_ready high at edge j: out_valid = 0 and in_ready = 1 after edge j. The next accept is at edge j+1 at the earliest.
- in_valid while busy is ignored; upstream must hold its data until in_ready.
- rst_n asserted mid-division: immediate return to IDLE, out_valid = 0, partial result discarded, no output produced.
- Both divisor-zero cases (V == 0, delta == 0) keep the full fixed latency unless the shortcut below is compiled in.

## Configuration
- Macro: HSV_GRAY_SHORTCUT_EN.
- **Defined:** if delta == 0 at accept, the stage goes directly IDLE→DONE with H = 0 and S = 0. out_valid is high after edge k (latency 0 extra cycles); the divider is not exercised.
- **Undefined:** grey pixels take the normal 32-cycle path and yield the same H = 0, S = 0.

## Test plan
- R=255, G=0, B=0, V=255, min=0 -> H=0, S=255, V_out=255, with out_valid exactly 32 cycles after accept.
- R=100, G=50, B=200, V=200, min=50 -> H=260, S=191, V_out=200.
- R=255, G=0, B=128, V=255, min=0 -> negative hue branch, H=330, S=255; then R=0, G=255, B=0 -> H=120.
- Grey R=G=B=100, V=min=100 -> H=0, S=0, V_out=100. Latency 32 without HSV_GRAY_SHORTCUT_EN, 0 extra cycles with it. Black 0,0,0 -> all outputs 0, no X.
- Hold out_ready low for 10 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored. Release -> handshake completes and the second pixel is accepted on the next cycle.
- Assert rst_n low at cycle 10 of DIV_S -> out_valid=0, H=S=V_out=0, in_ready=1. After release, a fresh pixel produces the correct result.
